// File: rtl/uart_tx_queue.sv
// uart_tx_queue
//   Byte FIFO plus handshake FSM feeding the transmit side of the UART
//   controller. The producer writes bytes at system-clock rate; the FSM pops
//   one byte at a time, raises tx_start, waits for the controller's tx_busy
//   to rise and then fall, and pulses sent when the byte has gone out.
//
// Optional feature (macro UART_TXQ_TIMEOUT_EN):
//   When defined, a START state that sees no tx_busy within START_TIMEOUT
//   clocks abandons the byte, sets the sticky timeout_err and returns to IDLE.
//   When undefined, the timeout_err port and its counter do not exist.
//
// Ports:
//   clk          system clock (shared with the UART controller)
//   reset        asynchronous, active-high reset
//   clear        synchronous flush of queued bytes, overflow (and timeout_err)
//   wr_data      byte to enqueue
//   wr_en        enqueue strobe
//   full/empty   registered FIFO status
//   level        registered number of queued bytes, 0..DEPTH
//   overflow     sticky: a write was dropped because the FIFO was full
//   tx_data      byte presented to the controller, stable for the transfer
//   tx_start     transmit request to the controller
//   tx_busy      controller busy flag (asynchronous, synchronised here)
//   sent         one-clk pulse when a byte's transmission completes
//   timeout_err  sticky start-timeout flag (UART_TXQ_TIMEOUT_EN only)

module uart_tx_queue #(
  parameter int DEPTH         = 16,
  parameter int ADDR_WIDTH    = 4,
  parameter int START_TIMEOUT = 65535
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic [7:0]            wr_data,
  input  logic                  wr_en,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  overflow,
  output logic [7:0]            tx_data,
  output logic                  tx_start,
  input  logic                  tx_busy,
  output logic                  sent
`ifdef UART_TXQ_TIMEOUT_EN
  ,
  output logic                  timeout_err
`endif
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t state;
  state_t state_nxt;

  logic [7:0]          mem [DEPTH];
  logic [ADDR_WIDTH:0] wr_ptr;
  logic [ADDR_WIDTH:0] rd_ptr;
  logic [ADDR_WIDTH:0] wr_ptr_nxt;
  logic [ADDR_WIDTH:0] rd_ptr_nxt;

  logic busy_p0;
  logic busy_s;
  logic push;
  logic pop;
  logic timeout_hit;

  // Stage p0 -> busy_s: two-flop synchroniser for the baud-domain busy flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_p0 <= 1'b0;
      busy_s  <= 1'b0;
    end else begin
      busy_p0 <= tx_busy;
      busy_s  <= busy_p0;
    end
  end

  // full is the registered flag, so a write meeting a same-cycle pop on a
  // full queue is still dropped. A write during clear is discarded, and no
  // pop is started while the pointers are being flushed.
  assign push = wr_en && !full && !clear;
  assign pop  = (state == IDLE) && !empty && !busy_s && !clear;

  always_comb begin
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    if (clear) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
    end else begin
      if (push) wr_ptr_nxt = wr_ptr + PTR_ONE;
      if (pop)  rd_ptr_nxt = rd_ptr + PTR_ONE;
    end
  end

  // Storage is not reset; only the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[ADDR_WIDTH-1:0]] <= wr_data;
  end

  // Status flags are computed from the next pointer values so that they are
  // registered yet consistent with the pointers on every cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr_nxt;
      rd_ptr   <= rd_ptr_nxt;
      full     <= (wr_ptr_nxt[ADDR_WIDTH-1:0] == rd_ptr_nxt[ADDR_WIDTH-1:0]) &&
                  (wr_ptr_nxt[ADDR_WIDTH] != rd_ptr_nxt[ADDR_WIDTH]);
      empty    <= (wr_ptr_nxt == rd_ptr_nxt);
      level    <= wr_ptr_nxt - rd_ptr_nxt;
      if (clear)
        overflow <= 1'b0;
      else if (wr_en && full)
        overflow <= 1'b1;
    end
  end

  // tx_data is loaded on the pop and held until the next pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      tx_data <= '0;
    else if (pop)
      tx_data <= mem[rd_ptr[ADDR_WIDTH-1:0]];
  end

`ifdef UART_TXQ_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(START_TIMEOUT - 1);

  logic [15:0] start_cnt;

  // Counts cycles spent in START; it is zero on the first START cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      start_cnt <= '0;
    else if (state != START)
      start_cnt <= '0;
    else
      start_cnt <= start_cnt + 16'd1;
  end

  assign timeout_hit = (state == START) && (start_cnt == TIMEOUT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      timeout_err <= 1'b0;
    else if (clear)
      timeout_err <= 1'b0;
    else if (timeout_hit && !busy_s)
      timeout_err <= 1'b1;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (pop) state_nxt = START;
      end
      START: begin
        if (busy_s)
          state_nxt = WAIT_DONE;
        else if (timeout_hit)
          state_nxt = IDLE;
      end
      WAIT_DONE: begin
        if (!busy_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs. Both depend on the synchronised busy flag so that tx_start
  // falls, and sent fires, in the same cycle the FSM sees the busy edge.
  always_comb begin
    tx_start = 1'b0;
    sent     = 1'b0;
    case (state)
      START:     tx_start = !busy_s;
      WAIT_DONE: sent     = !busy_s;
      default: begin
        tx_start = 1'b0;
        sent     = 1'b0;
      end
    endcase
  end

endmodule
